// File: rtl/mux_share_arbiter.sv
// Round-robin burst arbiter that shares a 1-of-2 selector between requesters A and B.
// The selector output is registered and marked with a one-cycle valid strobe per transfer.
module mux_share_arbiter #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             last_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] z,
  output logic             z_valid,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_A = 2'd1;
  localparam logic [1:0] GRANT_B = 2'd2;

  localparam logic SERVED_A = 1'b0;
  localparam logic SERVED_B = 1'b1;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] count;
  logic          last_served;
  logic          xfer_a;
  logic          xfer_b;
  logic          rel_a;
  logic          rel_b;

  assign gnt_a = (state == GRANT_A);
  assign gnt_b = (state == GRANT_B);
  assign sel   = (state == GRANT_B);
  assign busy  = (state != IDLE);

  assign xfer_a = gnt_a && req_a;
  assign xfer_b = gnt_b && req_b;

  // A dropped request releases without a transfer; otherwise last or the burst cap ends it.
  assign rel_a = gnt_a && (!req_a || last_a || (count == CAP));
  assign rel_b = gnt_b && (!req_b || last_b || (count == CAP));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          state_nxt = (last_served == SERVED_B) ? GRANT_A : GRANT_B;
        end else if (req_a) begin
          state_nxt = GRANT_A;
        end else if (req_b) begin
          state_nxt = GRANT_B;
        end
      end
      GRANT_A: begin
        if (rel_a) begin
          state_nxt = req_b ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        if (rel_b) begin
          state_nxt = req_a ? GRANT_A : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      last_served <= SERVED_B;
    end else begin
      state <= state_nxt;
      // Any move into a grant state (from IDLE or a direct switch) starts a fresh burst.
      if ((state_nxt != IDLE) && (state_nxt != state)) begin
        count       <= '0;
        last_served <= (state_nxt == GRANT_B) ? SERVED_B : SERVED_A;
      end else if (xfer_a || xfer_b) begin
        count <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z       <= '0;
      z_valid <= 1'b0;
    end else begin
      z_valid <= xfer_a || xfer_b;
      if (xfer_a || xfer_b) begin
        z <= sel ? data_b : data_a;
      end
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench for mux_share_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level model of the arbitration rules.
module tb_mux_share_arbiter;

  localparam int WIDTH     = 4;
  localparam int MAX_BURST = 4;

  logic             clk;
  logic             reset;
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             last_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             last_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic [WIDTH-1:0] z;
  logic             z_valid;
  logic             busy;

  int total_checks;
  int bad_checks;

  // Model: owner 0 = nobody, 1 = A, 2 = B; served counts completed transfers in this grant.
  int               m_owner;
  int               m_served;
  int               m_prev;
  logic [WIDTH-1:0] m_z;
  logic             m_zv;

  mux_share_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_a   (req_a),
    .data_a  (data_a),
    .last_a  (last_a),
    .req_b   (req_b),
    .data_b  (data_b),
    .last_b  (last_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .sel     (sel),
    .z       (z),
    .z_valid (z_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic grantTo(input int who);
    m_owner  = who;
    m_served = 0;
    m_prev   = who;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    logic r;
    logic l;
    logic [WIDTH-1:0] d;
    bit done;
    if (reset) begin
      m_owner  = 0;
      m_served = 0;
      m_prev   = 2;
      m_z      = '0;
      m_zv     = 1'b0;
      return;
    end
    m_zv = 1'b0;
    if (m_owner != 0) begin
      r = (m_owner == 1) ? req_a : req_b;
      l = (m_owner == 1) ? last_a : last_b;
      d = (m_owner == 1) ? data_a : data_b;
      done = 1'b1;
      if (r) begin
        m_z  = d;
        m_zv = 1'b1;
        m_served++;
        done = l || (m_served >= MAX_BURST);
      end
      if (done) begin
        if ((m_owner == 1) ? req_b : req_a) grantTo(3 - m_owner);
        else m_owner = 0;
      end
    end else if (req_a && req_b) begin
      grantTo((m_prev == 1) ? 2 : 1);
    end else if (req_a) begin
      grantTo(1);
    end else if (req_b) begin
      grantTo(2);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ra, input logic la, input logic [WIDTH-1:0] da,
                               input logic rb, input logic lb, input logic [WIDTH-1:0] db);
    @(negedge clk);
    reset  = rst;
    req_a  = ra;
    last_a = la;
    data_a = da;
    req_b  = rb;
    last_b = lb;
    data_b = db;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("gnt_a",   32'(gnt_a),   32'(m_owner == 1));
    checkOutput("gnt_b",   32'(gnt_b),   32'(m_owner == 2));
    checkOutput("sel",     32'(sel),     32'(m_owner == 2));
    checkOutput("busy",    32'(busy),    32'(m_owner != 0));
    checkOutput("z",       32'(z),       32'(m_z));
    checkOutput("z_valid", 32'(z_valid), 32'(m_zv));
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    m_owner = 0; m_served = 0; m_prev = 2; m_z = '0; m_zv = 1'b0;
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
    data_a = '0; data_b = '0;

    // Reset with both requests high, then A wins the first tie.
    applyStimulus(1, 1, 0, 4'h5, 1, 0, 4'hA);
    applyStimulus(1, 1, 0, 4'h5, 1, 0, 4'hA);
    applyStimulus(0, 1, 0, 4'h5, 1, 0, 4'hA);
    applyStimulus(1, 0, 0, 4'h0, 0, 0, 4'h0);

    // Single A burst 1,0,1 with last on the third word.
    applyStimulus(0, 1, 0, 4'h1, 0, 0, 4'h0);
    applyStimulus(0, 1, 0, 4'h1, 0, 0, 4'h0);
    applyStimulus(0, 1, 0, 4'h0, 0, 0, 4'h0);
    applyStimulus(0, 1, 1, 4'h1, 0, 0, 4'h0);
    applyStimulus(0, 0, 0, 4'h0, 0, 0, 4'h0);
    applyStimulus(0, 0, 0, 4'h0, 0, 0, 4'h0);

    // Burst cap: A never signals last while B waits.
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 4'(i), 1, 0, 4'(8 + i));
    applyStimulus(0, 0, 0, 4'h0, 0, 0, 4'h0);

    // Drop mid-burst after two B transfers.
    applyStimulus(0, 0, 0, 4'h0, 1, 0, 4'h3);
    applyStimulus(0, 0, 0, 4'h0, 1, 0, 4'h3);
    applyStimulus(0, 0, 0, 4'h0, 1, 0, 4'h6);
    applyStimulus(0, 0, 0, 4'h0, 0, 1, 4'h9);
    applyStimulus(0, 0, 0, 4'h0, 0, 0, 4'h0);

    // Reset during the second B transfer, then a tie goes to A.
    applyStimulus(0, 0, 0, 4'h0, 1, 0, 4'h7);
    applyStimulus(0, 0, 0, 4'h0, 1, 0, 4'h7);
    applyStimulus(1, 0, 0, 4'h0, 1, 0, 4'hE);
    applyStimulus(0, 1, 0, 4'h2, 1, 0, 4'hD);
    applyStimulus(0, 1, 1, 4'h4, 1, 0, 4'hD);
    applyStimulus(0, 0, 0, 4'h0, 1, 1, 4'hC);
    applyStimulus(0, 0, 0, 4'h0, 0, 0, 4'h0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2), WIDTH'($urandom),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2), WIDTH'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
